fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of an async_fifo among NUM_REQ requesters in the write-clock domain.
- Grants are burst-locked: a winner keeps the port until it signals last or hits MAX_BURST beats. The arbiter then passes ownership to the next requester in round-robin order.
- Sits directly in front of async_fifo wEn/wData/full. Fully single-clock; no CDC inside.

Parameters:
- NUM_REQ, 4, number of requesters (>=2, power of 2 not required)
- DATA_WIDTH, 32, width of each requester's data and of fifo_wData
- MAX_BURST, 8, maximum beats per grant (>=1)
- ID_WIDTH, $clog2(NUM_REQ) (localparam), width of grant_id and the rr pointer

Ports:
- clk  in  1  write-domain clock (same clock as the FIFO wClk)
- arst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester data valid
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  marks the final beat of requester's burst
- req_ready  out  NUM_REQ  one-hot or zero; beat from i accepted when req_valid[i] & req_ready[i]
- fifo_wEn  out  1  write enable to FIFO
- fifo_wData  out  DATA_WIDTH  write data to FIFO
- fifo_full  in  1  FIFO full flag
- grant_valid  out  1  a burst grant is active
- grant_id  out  ID_WIDTH  index of the current owner; valid only while grant_valid=1

Behaviour:
- Reset (async, arst_n=0):
  - state=IDLE, grant_valid=0, grant_id=0, rr_ptr=0, beat_cnt=0.
  - req_ready=0 and fifo_wEn=0 while in reset.
  - Reset mid-burst drops the burst immediately. No partial-burst recovery.
- State IDLE:
  - req_ready=0, fifo_wEn=0.
  - If any req_valid is set, select the first set bit searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register the selected index into grant_id, set grant_valid=1, beat_cnt=0, and go to BURST next cycle.
  - If no req_valid is set, stay in IDLE.
  - Arbitration costs exactly 1 cycle. A new burst's first beat is accepted no earlier than the cycle after the request is seen.
- State BURST (owner g=grant_id):
  - Combinational outputs:
    - req_ready[g] = ~fifo_full; all other req_ready bits = 0.
    - fifo_wEn = req_valid[g] & ~fifo_full.
    - fifo_wData = req_data[g] slice, driven regardless of wEn.
  - Beat = fifo_wEn=1. On each beat, beat_cnt increments.
  - Burst end = a beat with req_last[g]=1, or a beat with beat_cnt==MAX_BURST-1.
  - On burst end, in the same edge: state<=IDLE, grant_valid<=0, rr_ptr<=(g+1) mod NUM_REQ (wrap from NUM_REQ-1 to 0).
  - If req_valid[g] deasserts mid-burst, hold the grant, no beat. The arbiter waits indefinitely; there is no timeout.
  - If fifo_full=1, hold the grant, no beat, beat_cnt unchanged.
  - Non-owner req_valid is ignored until IDLE.
- The arbiter never writes when fifo_full=1. The FIFO never sees wEn & full.
- beat_cnt width = $clog2(MAX_BURST)+1. No overflow is possible.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0.

Test Plan:
- Reset, then req_valid=4'b0001, req_last on beat 3, fifo_full=0:
  - grant_id=0 one cycle after valid.
  - 3 consecutive fifo_wEn pulses carrying requester-0 data.
  - grant_valid drops after beat 3, rr_ptr=1.
- All 4 requesters valid, never last, MAX_BURST=8:
  - Grants in order 0,1,2,3,0, each exactly 8 beats.
  - One idle cycle (fifo_wEn=0) between bursts.
- Owner 2 mid-burst, fifo_full pulses high for 5 cycles:
  - fifo_wEn=0 and req_ready[2]=0 during those cycles.
  - Beat count resumes unchanged; total beats still 8.
- rr_ptr=3, req_valid=4'b1001:
  - Requester 3 wins first.
  - Then requester 0 wins, with rr_ptr wrapping 3→0→1.
- Owner 1 deasserts req_valid for 4 cycles mid-burst while requester 2 is valid:
  - Grant stays with 1, req_ready[2]=0, no writes.
  - Burst resumes when req_valid[1] returns.
- Assert arst_n=0 mid-burst (beat 4 of 8):
  - grant_valid, fifo_wEn and req_ready all go 0 immediately.
  - After release, the next grant starts from rr_ptr=0.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
//   Bundles the requester-side handshake, the async_fifo write port and the
//   grant status of fifo_wr_arbiter. All signals live in the FIFO write-clock
//   domain.
//
//   Signals:
//     req_valid   [NUM_REQ]             per-requester data valid
//     req_data    [NUM_REQ*DATA_WIDTH]  packed data, requester i at
//                                       [i*DATA_WIDTH +: DATA_WIDTH]
//     req_last    [NUM_REQ]             final beat of a requester's burst
//     req_ready   [NUM_REQ]             one-hot or zero accept strobe
//     fifo_wEn                          FIFO write enable
//     fifo_wData  [DATA_WIDTH]          FIFO write data
//     fifo_full                         FIFO full flag
//     grant_valid                       a burst grant is active
//     grant_id    [ID_WIDTH]            current owner (valid with grant_valid)
//
//   Modports:
//     master  requesters + FIFO side (drives requests and fifo_full)
//     slave   the arbiter itself
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned ID_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wEn;
  logic [DATA_WIDTH-1:0]         fifo_wData;
  logic                          fifo_full;
  logic                          grant_valid;
  logic [ID_WIDTH-1:0]           grant_id;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wEn, fifo_wData, grant_valid, grant_id
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wEn, fifo_wData, grant_valid, grant_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin, burst-locked arbiter sharing the single write port of an
//   async_fifo among NUM_REQ requesters. Single clock domain (FIFO wClk).
//
//   A requester that wins keeps the port until it writes a beat flagged with
//   req_last or until it has written MAX_BURST beats. Ownership then returns
//   to IDLE and the round-robin pointer moves to the requester after the
//   previous owner. Arbitration takes one cycle with no beat accepted.
//
//   Ports:
//     clk     write-domain clock (same as FIFO wClk)
//     arst_n  asynchronous active-low reset; drops any burst in flight
//     bus     fifo_wr_arbiter_if.slave (requests, FIFO port, grant status)
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 8
) (
  input logic           clk,
  input logic           arst_n,
  fifo_wr_arbiter_if.slave bus
);

  localparam int unsigned ID_WIDTH  = $clog2(NUM_REQ);
  localparam int unsigned CNT_WIDTH = $clog2(MAX_BURST) + 1;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StBurst = 1'b1;

  localparam logic [CNT_WIDTH-1:0] LastBeatCnt = CNT_WIDTH'(MAX_BURST - 1);
  localparam logic [ID_WIDTH-1:0]  LastId      = ID_WIDTH'(NUM_REQ - 1);

  logic [0:0]           stateQ, stateD;
  logic [ID_WIDTH-1:0]  grantIdQ, grantIdD;
  logic [ID_WIDTH-1:0]  rrPtrQ, rrPtrD;
  logic [CNT_WIDTH-1:0] beatCntQ, beatCntD;

  // ---------------------------------------------------------------------------
  // Round-robin pick: first valid requester scanning rrPtr, rrPtr+1, ...
  // ---------------------------------------------------------------------------
  logic                pickFound;
  logic [ID_WIDTH-1:0] pickId;
  logic [31:0]         scanIdx;

  always_comb begin
    pickFound = 1'b0;
    pickId    = '0;
    scanIdx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scanIdx = (32'(rrPtrQ) + k) % NUM_REQ;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!pickFound && (scanIdx == j) && bus.req_valid[j]) begin
          pickFound = 1'b1;
          pickId    = ID_WIDTH'(j);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Owner view: mux the granted requester's signals.
  // ---------------------------------------------------------------------------
  logic                  ownerValid;
  logic                  ownerLast;
  logic [DATA_WIDTH-1:0] ownerData;

  always_comb begin
    ownerValid = 1'b0;
    ownerLast  = 1'b0;
    ownerData  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grantIdQ == ID_WIDTH'(i)) begin
        ownerValid = bus.req_valid[i];
        ownerLast  = bus.req_last[i];
        ownerData  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  logic inBurst;
  logic beat;
  logic burstEnd;

  assign inBurst  = (stateQ == StBurst);
  // fifo_full gates the beat, so the FIFO can never see wEn together with full.
  assign beat     = inBurst & ownerValid & ~bus.fifo_full;
  assign burstEnd = beat & (ownerLast | (beatCntQ == LastBeatCnt));

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] readyVec;

  always_comb begin
    readyVec = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      readyVec[i] = inBurst & ~bus.fifo_full & (grantIdQ == ID_WIDTH'(i));
    end
  end

  assign bus.req_ready   = readyVec;
  assign bus.fifo_wEn    = beat;
  assign bus.fifo_wData  = ownerData;
  assign bus.grant_valid = inBurst;
  assign bus.grant_id    = grantIdQ;

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    stateD   = stateQ;
    grantIdD = grantIdQ;
    rrPtrD   = rrPtrQ;
    beatCntD = beatCntQ;

    case (stateQ)
      StIdle: begin
        if (pickFound) begin
          stateD   = StBurst;
          grantIdD = pickId;
          beatCntD = '0;
        end
      end
      StBurst: begin
        if (beat) begin
          beatCntD = beatCntQ + 1'b1;
        end
        if (burstEnd) begin
          stateD   = StIdle;
          beatCntD = '0;
          rrPtrD   = (grantIdQ == LastId) ? '0 : grantIdQ + 1'b1;
        end
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stateQ   <= StIdle;
      grantIdQ <= '0;
      rrPtrQ   <= '0;
      beatCntQ <= '0;
    end else begin
      stateQ   <= stateD;
      grantIdQ <= grantIdD;
      rrPtrQ   <= rrPtrD;
      beatCntQ <= beatCntD;
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol invariants
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  noWriteWhenFull: assert property (@(posedge clk) disable iff (!arst_n)
    !(bus.fifo_wEn && bus.fifo_full));

  readyOneHot: assert property (@(posedge clk) disable iff (!arst_n)
    $onehot0(bus.req_ready));

  wEnOnlyInBurst: assert property (@(posedge clk) disable iff (!arst_n)
    bus.fifo_wEn |-> bus.grant_valid);
`endif

endmodule
